// File: rtl/seq_mult_64.sv
// Iterative shift-add multiplier: one partial product per cycle, signed or unsigned,
// registered 2*WIDTH product with a one-cycle completion strobe.
module seq_mult_64 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     operand_a,
    input  logic [WIDTH-1:0]     operand_b,
    output logic                 busy,
    output logic                 result_valid,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned RW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]        state,  nxt_state;
    logic [WIDTH-1:0]  mcand,  nxt_mcand;
    logic [WIDTH-1:0]  mplier, nxt_mplier;
    logic [RW-1:0]     acc,    nxt_acc;
    logic [CW-1:0]     cnt,    nxt_cnt;
    logic              neg,    nxt_neg;
    logic              nxt_busy;
    logic              nxt_valid;
    logic [RW-1:0]     nxt_result;

    // Magnitude of an operand; the most-negative value maps onto itself as unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    // State register and datapath registers
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            state        <= IDLE;
            mcand        <= '0;
            mplier       <= '0;
            acc          <= '0;
            cnt          <= '0;
            neg          <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
        end else begin
            state        <= nxt_state;
            mcand        <= nxt_mcand;
            mplier       <= nxt_mplier;
            acc          <= nxt_acc;
            cnt          <= nxt_cnt;
            neg          <= nxt_neg;
            busy         <= nxt_busy;
            result_valid <= nxt_valid;
            result       <= nxt_result;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        nxt_state  = state;
        nxt_mcand  = mcand;
        nxt_mplier = mplier;
        nxt_acc    = acc;
        nxt_cnt    = cnt;
        nxt_neg    = neg;
        nxt_busy   = busy;
        nxt_valid  = 1'b0;
        nxt_result = result;

        case (state)
            IDLE: begin
                if (start) begin
                    nxt_mcand  = mag(operand_a, signed_op);
                    nxt_mplier = mag(operand_b, signed_op);
                    nxt_neg    = signed_op & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                    nxt_acc    = '0;
                    nxt_cnt    = '0;
                    nxt_busy   = 1'b1;
                    nxt_state  = RUN;
                end
            end
            RUN: begin
                if (mplier[0]) begin
                    nxt_acc = acc + (RW'(mcand) << cnt);
                end
                nxt_mplier = mplier >> 1;
                nxt_cnt    = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    nxt_state = FIX;
                end
            end
            FIX: begin
                // Negating zero yields zero, so no special case is needed.
                nxt_result = neg ? (~acc + RW'(1)) : acc;
                nxt_valid  = 1'b1;
                nxt_busy   = 1'b0;
                nxt_state  = IDLE;
            end
            default: begin
                nxt_busy  = 1'b0;
                nxt_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_mult_64.sv
// Self-checking bench for seq_mult_64: directed table, random vectors against an
// arithmetic reference, back-to-back starts, ignored starts and mid-run reset.
module tb_seq_mult_64;

    logic        clock;
    logic        clr;
    logic        start;
    logic        signed_op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        result_valid;
    logic [63:0] result;

    int nvec = 0;
    int nerr = 0;
    logic [63:0] last_res;

    seq_mult_64 #(.WIDTH(32)) dut (
        .clock        (clock),
        .clr          (clr),
        .start        (start),
        .signed_op    (signed_op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    // Reference product using plain 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'(int'(a));
            sb = longint'(int'(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        return 64'(sa * sb);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
        end
    endtask

    // Caller is positioned at a negedge; drives a start and lets edge E0 take it.
    task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
        start     = 1'b1;
        signed_op = s;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        start     = 1'b0;
        signed_op = 1'($urandom);
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    // Samples at each negedge; k counts edges after E0. Returns at the valid negedge.
    task automatic wait_result(input string nm, input int pulse_at, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clock);
            if (busy) bcnt++;
            if (k == 0) chk({nm, " valid_low_in_run"}, 64'(result_valid), 64'd0);
            if (k == 16) chk({nm, " result_held"}, result, last_res);
            if (k == pulse_at) begin
                start = 1'b1; signed_op = 1'b0; operand_a = 32'd2; operand_b = 32'd2;
            end else if (k == pulse_at + 1) begin
                start = 1'b0;
            end
            if (result_valid) begin
                lat = k;
                return;
            end
        end
    endtask

    task automatic do_vec(input string nm, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int pulse_at);
        int lat;
        int bcnt;
        launch(s, a, b);
        wait_result(nm, pulse_at, lat, bcnt);
        chk({nm, " latency"}, 64'(lat), 64'd33);
        chk({nm, " busy_cycles"}, 64'(bcnt), 64'd33);
        chk({nm, " result"}, result, exp);
        last_res = exp;
    endtask

    // Watches n cycles and reports how many result_valid pulses appeared.
    task automatic count_valids(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            if (result_valid) cnt++;
        end
    endtask

    initial begin
        vec_t vt[7];
        int   nv;
        logic s;
        logic [31:0] a;
        logic [31:0] b;

        vt[0] = '{"uns_max",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vt[1] = '{"sgn_m3x7",    1'b1, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB};
        vt[2] = '{"sgn_min_sq",  1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vt[3] = '{"sgn_min_x1",  1'b1, 32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000};
        vt[4] = '{"sgn_zero",    1'b1, 32'd0,         32'hFFFF_FFFF, 64'd0};
        vt[5] = '{"uns_min_x2",  1'b0, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000};
        vt[6] = '{"uns_m3x7",    1'b0, 32'hFFFF_FFFD, 32'd7,         64'h0000_0006_FFFF_FFEB};

        clr = 1'b0; start = 1'b0; signed_op = 1'b0; operand_a = '0; operand_b = '0;
        last_res = '0;
        #12;
        chk("reset busy",   64'(busy), 64'd0);
        chk("reset valid",  64'(result_valid), 64'd0);
        chk("reset result", result, 64'd0);
        @(negedge clock);
        clr = 1'b1;
        @(negedge clock);

        foreach (vt[i]) begin
            do_vec(vt[i].name, vt[i].s, vt[i].a, vt[i].b, vt[i].exp, -1);
            @(negedge clock);
        end

        // Start during run is ignored; then back-to-back start in the valid cycle.
        do_vec("repulse_6x7", 1'b0, 32'd6, 32'd7, 64'h2A, 10);
        do_vec("b2b_zero", 1'b0, 32'd0, 32'h1234_5678, 64'd0, -1);
        count_valids(40, nv);
        chk("no_extra_valid", 64'(nv), 64'd0);

        // Random vectors, alternating back-to-back and idle gaps.
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            a = $urandom;
            b = $urandom;
            if (i % 8 == 3) a = 32'h8000_0000;
            if (i % 8 == 5) b = 32'hFFFF_FFFF;
            do_vec("random", s, a, b, ref_mul(s, a, b), -1);
            if (i % 2 == 1) repeat ($urandom_range(1, 3)) @(negedge clock);
        end
        @(negedge clock);

        // Asynchronous reset mid-run discards the multiply.
        launch(1'b0, 32'd5, 32'd5);
        repeat (15) @(negedge clock);
        #1 clr = 1'b0;
        #1;
        chk("midrst busy",   64'(busy), 64'd0);
        chk("midrst valid",  64'(result_valid), 64'd0);
        chk("midrst result", result, 64'd0);
        #4 clr = 1'b1;
        last_res = '0;
        count_valids(40, nv);
        chk("midrst no_valid", 64'(nv), 64'd0);
        do_vec("after_rst_3x4", 1'b0, 32'd3, 32'd4, 64'hC, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
